alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU between two requesters: port 0 (core execute
//  stage) and port 1 (secondary unit, e.g. MMIO accelerator/debug).
//  Arbitrates with valid/ready handshakes and drives the shared ALU's op/operand
//  inputs. Captures the ALU result in a register and returns it to the granted
//  requester with a response handshake. Sits between the requesters and ALU/ALUdec.
// PARAMETERS
//  WIDTH       32  operand/result width
//  STARVE_MAX  4   max consecutive port-0 wins before port 1 is forced (PRIO mode only)
// PORTS
//  clk          in   1      clock; all state updates on rising edge
//  rst          in   1      synchronous reset, active-high
//  req_valid    in   2      per-port request valid ([0]=core, [1]=secondary)
//  req_ready    out  2      per-port request accepted this cycle (one-hot or 0)
//  req_op0      in   4      port-0 ALUop (ALUop.vh encoding)
//  req_a0/b0    in   WIDTH  port-0 operands
//  req_op1      in   4      port-1 ALUop
//  req_a1/b1    in   WIDTH  port-1 operands
//  alu_op       out  4      to shared ALU
//  alu_a/alu_b  out  WIDTH  to shared ALU
//  alu_out      in   WIDTH  shared ALU result (combinational from alu_op/a/b)
//  resp_valid   out  2      per-port response valid (one-hot or 0)
//  resp_data    out  WIDTH  registered result, shared by both ports
//  resp_ready   in   2      per-port response accept
// BEHAVIOUR
//  - Reset: state=IDLE, req_ready=0, resp_valid=0, resp_data=0, last_grant=1
//    (so port 0 wins first tie), starve_cnt=0. alu_op/a/b = port-0 inputs
//    (mux select reset to 0).
//  - FSM: IDLE, RESP.
//    IDLE: if any req_valid, grant one port g; req_ready[g]=1 same cycle
//      (combinational); alu_* driven from port g; at edge resp_data<=alu_out,
//      resp_owner<=g, ->RESP. No req_valid -> stay IDLE, req_ready=0.
//    RESP: resp_valid[resp_owner]=1, resp_data stable. If
//      resp_ready[resp_owner]=1 this cycle: response completes; a new grant may
//      be issued in the same cycle (back-to-back, stay RESP with new data),
//      else ->IDLE. If resp_ready low: hold, req_ready=0, no new grant.
//  - Latency: grant cycle N -> resp_valid at N+1. Throughput 1 op/cycle when the
//    owner holds resp_ready high.
//  - Arbitration (default): round-robin; on both valid, grant != last_grant.
//    last_grant updates only on an actual grant.
//  - req_valid must stay asserted with stable op/operands until req_ready;
//    dropping req_valid before grant withdraws the request (legal).
//  - resp_ready on the non-owner port is ignored.
//  - ALU_XXX or unused ALUop codes pass through unchanged; no checking.
//  - Reset mid-operation: pending response discarded, resp_valid=0 next cycle,
//    no handshake completes in the reset cycle.
//  - req_ready and resp_valid never assert in the same cycle for the same port
//    unless the back-to-back completion rule applies.
// CONFIGURATION
//  ALU_ARB_PRIO_EN defined: fixed priority to port 0 with anti-starvation.
//    starve_cnt increments on each port-0 grant while req_valid[1]=1, clears on
//    a port-1 grant or when req_valid[1]=0. When starve_cnt==STARVE_MAX and
//    req_valid[1]=1, port 1 is granted.
//  Not defined: pure round-robin as above; STARVE_MAX unused, no starve_cnt.
// TESTING
//  1 Reset then req_valid=01, op=ALU_ADD, a0=5, b0=7 -> req_ready=01 same
//    cycle; next cycle resp_valid=01, resp_data=12.
//  2 Both valid every cycle, resp_ready=11 -> grants alternate 0,1,0,1
//    (round robin); one response per cycle, data matches the owner's op.
//  3 Owner holds resp_ready=0 for 3 cycles -> resp_data/resp_valid stable,
//    req_ready=00 throughout; grant resumes the cycle resp_ready rises.
//  4 ALU_SUB a1=3, b1=5 on port 1 -> resp_data=32'hFFFFFFFE, resp_valid=10.
//  5 rst asserted while in RESP -> next cycle resp_valid=00, resp_data=0,
//    first grant after reset goes to port 0 on tie.
//  6 ALU_ARB_PRIO_EN, STARVE_MAX=4, both valid continuously -> grant pattern
//    0,0,0,0,1 repeating; without the macro -> 0,1,0,1.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Requester-side bus of alu_share_arbiter.
// Both requesters share this bus. Bit/port 0 is the core execute stage and
// bit/port 1 is the secondary unit.
//   req_valid/req_ready    per-port request handshake
//   req_op0/a0/b0          port-0 ALUop and operands
//   req_op1/a1/b1          port-1 ALUop and operands
//   resp_valid/resp_ready  per-port response handshake
//   resp_data              registered result, shared by both ports
// Modports:
//   slave   the arbiter side
//   master  the requester side
interface alu_share_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [3:0]       req_op0;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_b0;
  logic [3:0]       req_op1;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b1;
  logic [1:0]       resp_valid;
  logic [WIDTH-1:0] resp_data;
  logic [1:0]       resp_ready;

  modport slave (
    input  req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1, resp_ready,
    output req_ready, resp_valid, resp_data
  );

  modport master (
    output req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1, resp_ready,
    input  req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// This module shares one combinational ALU between two requesters.
// Port 0 is the core and port 1 is the secondary unit.
// - A request is granted combinationally, in the same cycle as req_ready.
// - The ALU result is captured into resp_data at that clock edge.
// - The result is returned to the owner on the following cycle.
// - Back-to-back operation runs at one op per cycle while the owner holds
//   resp_ready high.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   bus (slave)          requester handshakes, operands and response
//   alu_op/alu_a/alu_b   to the shared ALU
//   alu_out              shared ALU result, combinational from alu_op/a/b
// Configuration:
//   ALU_ARB_PRIO_EN undefined  round-robin arbitration (STARVE_MAX unused)
//   ALU_ARB_PRIO_EN defined    fixed priority to port 0; port 1 is forced
//                              after STARVE_MAX consecutive port-0 wins
module alu_share_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_share_arbiter_if.slave bus,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic             resp_owner;
  logic             last_grant;
  logic             sel_q;
  logic             grant;
  logic             grant_port;
  logic             sel;
  logic [1:0]       req_ready;
  logic [1:0]       resp_valid;
  logic [WIDTH-1:0] resp_data;

`ifdef ALU_ARB_PRIO_EN
  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_cnt;
`endif

  // Arbitration between the two ports
  always_comb begin
    grant_port = 1'b0;
    unique case (bus.req_valid)
      2'b10:   grant_port = 1'b1;
`ifdef ALU_ARB_PRIO_EN
      2'b11:   grant_port = (starve_cnt == CNT_W'(STARVE_MAX));
`else
      2'b11:   grant_port = ~last_grant;
`endif
      default: grant_port = 1'b0;
    endcase
  end

  // FSM next state and handshake outputs.
  // In RESP, a completing response frees the slot for a same-cycle grant.
  // While rst is high, both handshakes are suppressed.
  always_comb begin
    logic can_grant;
    state_nxt  = state;
    can_grant  = 1'b0;
    req_ready  = '0;
    resp_valid = '0;
    unique case (state)
      IDLE: can_grant = 1'b1;
      RESP: begin
        resp_valid[resp_owner] = 1'b1;
        can_grant              = bus.resp_ready[resp_owner];
        if (can_grant) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      can_grant  = 1'b0;
      resp_valid = '0;
    end
    grant = can_grant && (|bus.req_valid);
    if (grant) begin
      req_ready[grant_port] = 1'b1;
      state_nxt             = RESP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Outside a grant cycle, the ALU keeps looking at the last granted port.
  assign sel    = grant ? grant_port : sel_q;
  assign alu_op = sel ? bus.req_op1 : bus.req_op0;
  assign alu_a  = sel ? bus.req_a1  : bus.req_a0;
  assign alu_b  = sel ? bus.req_b1  : bus.req_b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_data  <= '0;
      resp_owner <= 1'b0;
      last_grant <= 1'b1;
      sel_q      <= 1'b0;
    end else if (grant) begin
      resp_data  <= alu_out;
      resp_owner <= grant_port;
      last_grant <= grant_port;
      sel_q      <= grant_port;
    end
  end

`ifdef ALU_ARB_PRIO_EN
  // Counts consecutive port-0 wins while port 1 is waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!bus.req_valid[1] || (grant && grant_port)) begin
      starve_cnt <= '0;
    end else if (grant && !grant_port && (starve_cnt != CNT_W'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_data  = resp_data;

endmodule
